// File: rtl/mem_align_pkg.sv
// mem_align_pkg: op/exception/state encodings and store-lane helpers
package mem_align_pkg;

    typedef enum logic [2:0] {
        OP_LW  = 3'b000,
        OP_LH  = 3'b001,
        OP_LHU = 3'b010,
        OP_LB  = 3'b011,
        OP_LBU = 3'b100,
        OP_SW  = 3'b101,
        OP_SH  = 3'b110,
        OP_SB  = 3'b111
    } op_t;

    typedef enum logic [1:0] {
        EXC_NONE = 2'b00,
        EXC_ADEL = 2'b01,
        EXC_ADES = 2'b10
    } exc_t;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        ISSUE = 2'b01,
        WAIT  = 2'b10,
        RESP  = 2'b11
    } state_t;

    function automatic logic is_store(op_t op);
        return op == OP_SW || op == OP_SH || op == OP_SB;
    endfunction

    // Words need a[1:0]==0, halfwords need a[0]==0, bytes are always aligned.
    function automatic logic misaligned(op_t op, logic [1:0] a);
        return (op == OP_LW || op == OP_SW) ? a != 2'b00 :
               (op == OP_LH || op == OP_LHU || op == OP_SH) ? a[0] : 1'b0;
    endfunction

    function automatic logic [3:0] store_we(op_t op, logic [1:0] a);
        return op == OP_SB ? 4'b0001 << a :
               op == OP_SH ? (a[1] ? 4'b1100 : 4'b0011) :
               op == OP_SW ? 4'b1111 : 4'b0000;
    endfunction

    // Sub-word data is replicated across lanes so the byte enables alone pick the target.
    function automatic logic [31:0] store_data(op_t op, logic [31:0] w);
        return op == OP_SB ? {4{w[7:0]}} :
               op == OP_SH ? {2{w[15:0]}} :
               op == OP_SW ? w : 32'b0;
    endfunction

endpackage

// File: rtl/mem_align_if.sv
// mem_align_if: MEM-stage request/response and data-memory bus bundle
interface mem_align_if;

    logic        req_valid;
    logic        req_ready;
    logic [2:0]  req_op;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        dm_en;
    logic [3:0]  dm_we;
    logic [31:0] dm_addr;
    logic [31:0] dm_wdata;
    logic        dm_rvalid;
    logic [31:0] dm_rdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic [1:0]  rsp_exc;
    logic [31:0] rsp_badaddr;

    modport master (
        output req_valid, req_op, req_addr, req_wdata, dm_rvalid, dm_rdata,
        input  req_ready, dm_en, dm_we, dm_addr, dm_wdata,
               rsp_valid, rsp_rdata, rsp_exc, rsp_badaddr
    );

    modport slave (
        input  req_valid, req_op, req_addr, req_wdata, dm_rvalid, dm_rdata,
        output req_ready, dm_en, dm_we, dm_addr, dm_wdata,
               rsp_valid, rsp_rdata, rsp_exc, rsp_badaddr
    );

endinterface

// File: rtl/mem_align_ld_ext.sv
// mem_align_ld_ext: extracts and sign/zero-extends the addressed load lane
module mem_align_ld_ext
    import mem_align_pkg::*;
(
    input  op_t         op,
    input  logic [1:0]  addr,
    input  logic [31:0] rdata,
    output logic [31:0] data
);

    logic [7:0]  b;
    logic [15:0] h;

    // Little-endian lane select followed by width-dependent extension
    always_comb begin
        b = rdata[{addr, 3'b000} +: 8];
        h = addr[1] ? rdata[31:16] : rdata[15:0];
        data = op == OP_LB  ? {{24{b[7]}}, b} :
               op == OP_LBU ? {24'b0, b} :
               op == OP_LH  ? {{16{h[15]}}, h} :
               op == OP_LHU ? {16'b0, h} : rdata;
    end

endmodule

// File: rtl/mem_align.sv
// mem_align: load/store alignment unit between the MEM stage and data memory
module mem_align
    import mem_align_pkg::*;
(
    input logic        clk,
    input logic        reset,
    mem_align_if.slave bus
);

    state_t      state, next;
    op_t         op_q;
    logic [1:0]  a_q;
    logic [31:0] dm_addr_q, dm_wdata_q;
    logic [3:0]  dm_we_q;
    logic [31:0] rsp_rdata_q, rsp_badaddr_q;
    exc_t        rsp_exc_q;
    logic [31:0] ext;
    logic        accept, bad;
    op_t         op_in;

    assign op_in  = op_t'(bus.req_op);
    assign accept = bus.req_valid && state == IDLE;
    assign bad    = misaligned(op_in, bus.req_addr[1:0]);

    mem_align_ld_ext u_ld_ext (
        .op    (op_q),
        .addr  (a_q),
        .rdata (bus.dm_rdata),
        .data  (ext)
    );

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= next;
    end

    // Next state: faults skip DM entirely, stores finish after the strobe, loads wait for data
    always_comb begin
        next = state;
        case (state)
            IDLE:    next = accept ? (bad ? RESP : ISSUE) : IDLE;
            ISSUE:   next = is_store(op_q) ? RESP : WAIT;
            WAIT:    next = bus.dm_rvalid ? RESP : WAIT;
            default: next = IDLE;
        endcase
    end

    // Request latch, DM request registers and response registers (updated only on entry to RESP)
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            op_q          <= OP_LW;
            a_q           <= 2'b00;
            dm_addr_q     <= 32'b0;
            dm_we_q       <= 4'b0;
            dm_wdata_q    <= 32'b0;
            rsp_rdata_q   <= 32'b0;
            rsp_exc_q     <= EXC_NONE;
            rsp_badaddr_q <= 32'b0;
        end else begin
            if (accept) begin
                op_q <= op_in;
                a_q  <= bus.req_addr[1:0];
            end
            if (accept && !bad) begin
                dm_addr_q  <= {bus.req_addr[31:2], 2'b00};
                dm_we_q    <= store_we(op_in, bus.req_addr[1:0]);
                dm_wdata_q <= store_data(op_in, bus.req_wdata);
            end
            if (accept && bad) begin
                rsp_rdata_q   <= 32'b0;
                rsp_exc_q     <= is_store(op_in) ? EXC_ADES : EXC_ADEL;
                rsp_badaddr_q <= bus.req_addr;
            end
            if (state == ISSUE && is_store(op_q)) begin
                rsp_rdata_q   <= 32'b0;
                rsp_exc_q     <= EXC_NONE;
                rsp_badaddr_q <= 32'b0;
            end
            if (state == WAIT && bus.dm_rvalid) begin
                rsp_rdata_q   <= ext;
                rsp_exc_q     <= EXC_NONE;
                rsp_badaddr_q <= 32'b0;
            end
        end
    end

    assign bus.req_ready   = state == IDLE;
    assign bus.dm_en       = state == ISSUE;
    assign bus.dm_we       = state == ISSUE ? dm_we_q : 4'b0000;
    assign bus.dm_addr     = dm_addr_q;
    assign bus.dm_wdata    = dm_wdata_q;
    assign bus.rsp_valid   = state == RESP;
    assign bus.rsp_rdata   = rsp_rdata_q;
    assign bus.rsp_exc     = rsp_exc_q;
    assign bus.rsp_badaddr = rsp_badaddr_q;

endmodule

// File: tb/tb_mem_align.sv
// tb_mem_align: directed self-checking bench for mem_align
module tb_mem_align;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   failures = 0;

    mem_align_if bus ();

    mem_align dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [2:0] op, input logic [31:0] addr, input logic [31:0] wdata);
        bus.req_valid = 1'b1;
        bus.req_op    = op;
        bus.req_addr  = addr;
        bus.req_wdata = wdata;
    endtask

    task automatic do_store(input string tag, input logic [2:0] op, input logic [31:0] addr,
                            input logic [31:0] wdata, input logic [3:0] we, input logic [31:0] wd);
        drive(op, addr, wdata);
        tick;
        bus.req_valid = 1'b0;
        chk({tag, "_dm_en"}, 32'(bus.dm_en), 32'd1);
        chk({tag, "_dm_we"}, 32'(bus.dm_we), 32'(we));
        chk({tag, "_dm_addr"}, bus.dm_addr, {addr[31:2], 2'b00});
        chk({tag, "_dm_wdata"}, bus.dm_wdata, wd);
        chk({tag, "_ready_busy"}, 32'(bus.req_ready), 32'd0);
        chk({tag, "_no_rsp_c1"}, 32'(bus.rsp_valid), 32'd0);
        tick;
        chk({tag, "_rsp_valid"}, 32'(bus.rsp_valid), 32'd1);
        chk({tag, "_rsp_exc"}, 32'(bus.rsp_exc), 32'd0);
        chk({tag, "_rsp_rdata"}, bus.rsp_rdata, 32'd0);
        chk({tag, "_dm_en_off"}, 32'(bus.dm_en), 32'd0);
        chk({tag, "_dm_we_off"}, 32'(bus.dm_we), 32'd0);
        tick;
        chk({tag, "_idle"}, 32'(bus.req_ready), 32'd1);
    endtask

    task automatic do_load(input string tag, input logic [2:0] op, input logic [31:0] addr,
                           input logic [31:0] rdata, input logic [31:0] exp);
        drive(op, addr, 32'hFFFF_FFFF);
        tick;
        bus.req_valid = 1'b0;
        chk({tag, "_dm_en"}, 32'(bus.dm_en), 32'd1);
        chk({tag, "_dm_we"}, 32'(bus.dm_we), 32'd0);
        chk({tag, "_dm_addr"}, bus.dm_addr, {addr[31:2], 2'b00});
        tick;
        chk({tag, "_wait_no_rsp"}, 32'(bus.rsp_valid), 32'd0);
        chk({tag, "_wait_dm_en"}, 32'(bus.dm_en), 32'd0);
        bus.dm_rvalid = 1'b1;
        bus.dm_rdata  = rdata;
        tick;
        bus.dm_rvalid = 1'b0;
        chk({tag, "_rsp_valid"}, 32'(bus.rsp_valid), 32'd1);
        chk({tag, "_rsp_rdata"}, bus.rsp_rdata, exp);
        chk({tag, "_rsp_exc"}, 32'(bus.rsp_exc), 32'd0);
        tick;
        chk({tag, "_idle"}, 32'(bus.req_ready), 32'd1);
    endtask

    task automatic do_bad(input string tag, input logic [2:0] op, input logic [31:0] addr,
                          input logic [1:0] exc);
        drive(op, addr, 32'h1234_5678);
        tick;
        bus.req_valid = 1'b0;
        chk({tag, "_dm_en"}, 32'(bus.dm_en), 32'd0);
        chk({tag, "_dm_we"}, 32'(bus.dm_we), 32'd0);
        chk({tag, "_rsp_valid"}, 32'(bus.rsp_valid), 32'd1);
        chk({tag, "_rsp_exc"}, 32'(bus.rsp_exc), 32'(exc));
        chk({tag, "_badaddr"}, bus.rsp_badaddr, addr);
        chk({tag, "_rsp_rdata"}, bus.rsp_rdata, 32'd0);
        tick;
        chk({tag, "_idle"}, 32'(bus.req_ready), 32'd1);
        chk({tag, "_rsp_off"}, 32'(bus.rsp_valid), 32'd0);
        chk({tag, "_exc_hold"}, 32'(bus.rsp_exc), 32'(exc));
    endtask

    initial begin
        reset         = 1'b1;
        bus.req_valid = 1'b0;
        bus.req_op    = 3'b000;
        bus.req_addr  = 32'd0;
        bus.req_wdata = 32'd0;
        bus.dm_rvalid = 1'b0;
        bus.dm_rdata  = 32'd0;
        tick;
        chk("rst_ready", 32'(bus.req_ready), 32'd1);
        chk("rst_dm_en", 32'(bus.dm_en), 32'd0);
        chk("rst_dm_we", 32'(bus.dm_we), 32'd0);
        chk("rst_dm_addr", bus.dm_addr, 32'd0);
        chk("rst_dm_wdata", bus.dm_wdata, 32'd0);
        chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("rst_rsp_rdata", bus.rsp_rdata, 32'd0);
        chk("rst_rsp_exc", 32'(bus.rsp_exc), 32'd0);
        chk("rst_badaddr", bus.rsp_badaddr, 32'd0);
        reset = 1'b0;
        tick;

        do_store("sb", 3'b111, 32'h0000_1003, 32'h0000_00A5, 4'b1000, 32'hA5A5_A5A5);
        do_store("sb0", 3'b111, 32'h0000_1000, 32'h0000_123C, 4'b0001, 32'h3C3C_3C3C);
        do_store("sh", 3'b110, 32'h0000_4002, 32'h0000_BEEF, 4'b1100, 32'hBEEF_BEEF);
        do_store("sh0", 3'b110, 32'h0000_4000, 32'h7777_1357, 4'b0011, 32'h1357_1357);
        do_store("sw", 3'b101, 32'h0000_4000, 32'hDEAD_BEEF, 4'b1111, 32'hDEAD_BEEF);

        do_load("lb", 3'b011, 32'h0000_2001, 32'h1234_8056, 32'hFFFF_FF80);
        do_load("lbu", 3'b100, 32'h0000_2001, 32'h1234_8056, 32'h0000_0080);
        do_load("lb3", 3'b011, 32'h0000_2003, 32'h1234_8056, 32'h0000_0012);
        do_load("lh", 3'b001, 32'h0000_2002, 32'h9ABC_1234, 32'hFFFF_9ABC);
        do_load("lhu", 3'b010, 32'h0000_2002, 32'h9ABC_1234, 32'h0000_9ABC);
        do_load("lh0", 3'b001, 32'h0000_2000, 32'h9ABC_F234, 32'hFFFF_F234);
        do_load("lw", 3'b000, 32'h0000_2000, 32'h9ABC_1234, 32'h9ABC_1234);

        do_bad("sw_mis", 3'b101, 32'h0000_3002, 2'b10);
        do_bad("lh_mis", 3'b001, 32'h0000_3001, 2'b01);
        do_bad("lw_mis", 3'b000, 32'h0000_3003, 2'b01);
        do_bad("sh_mis", 3'b110, 32'h0000_3001, 2'b10);

        // Delayed LW with req_valid held high; a dm_rvalid during ISSUE must be ignored
        drive(3'b000, 32'h0000_5000, 32'd0);
        tick;
        chk("dly_dm_en", 32'(bus.dm_en), 32'd1);
        chk("dly_ready_issue", 32'(bus.req_ready), 32'd0);
        bus.dm_rvalid = 1'b1;
        bus.dm_rdata  = 32'hFFFF_FFFF;
        tick;
        bus.dm_rvalid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("dly_ready_wait", 32'(bus.req_ready), 32'd0);
            chk("dly_no_rsp", 32'(bus.rsp_valid), 32'd0);
            chk("dly_no_dm_en", 32'(bus.dm_en), 32'd0);
            tick;
        end
        bus.dm_rvalid = 1'b1;
        bus.dm_rdata  = 32'h1122_3344;
        tick;
        bus.dm_rvalid = 1'b0;
        chk("dly_rsp_valid", 32'(bus.rsp_valid), 32'd1);
        chk("dly_rsp_rdata", bus.rsp_rdata, 32'h1122_3344);
        chk("dly_ready_resp", 32'(bus.req_ready), 32'd0);
        tick;
        chk("dly_ready_idle", 32'(bus.req_ready), 32'd1);
        chk("dly_rsp_off", 32'(bus.rsp_valid), 32'd0);
        tick;
        bus.req_valid = 1'b0;
        chk("dly_reaccept_en", 32'(bus.dm_en), 32'd1);
        tick;
        bus.dm_rvalid = 1'b1;
        bus.dm_rdata  = 32'hCAFE_F00D;
        tick;
        bus.dm_rvalid = 1'b0;
        chk("dly2_rsp_valid", 32'(bus.rsp_valid), 32'd1);
        chk("dly2_rsp_rdata", bus.rsp_rdata, 32'hCAFE_F00D);
        tick;

        // Stray dm_rvalid while idle
        bus.dm_rvalid = 1'b1;
        bus.dm_rdata  = 32'h0000_0055;
        tick;
        bus.dm_rvalid = 1'b0;
        chk("stray_no_rsp", 32'(bus.rsp_valid), 32'd0);
        chk("stray_ready", 32'(bus.req_ready), 32'd1);
        tick;
        chk("stray_no_rsp2", 32'(bus.rsp_valid), 32'd0);
        chk("stray_rdata_hold", bus.rsp_rdata, 32'hCAFE_F00D);

        // Reset pulsed while waiting for load data
        drive(3'b000, 32'h0000_6000, 32'd0);
        tick;
        bus.req_valid = 1'b0;
        tick;
        chk("rw_waiting", 32'(bus.req_ready), 32'd0);
        #2;
        reset = 1'b1;
        #1;
        chk("rw_ready", 32'(bus.req_ready), 32'd1);
        chk("rw_dm_en", 32'(bus.dm_en), 32'd0);
        chk("rw_dm_addr", bus.dm_addr, 32'd0);
        chk("rw_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("rw_rsp_rdata", bus.rsp_rdata, 32'd0);
        chk("rw_rsp_exc", 32'(bus.rsp_exc), 32'd0);
        chk("rw_badaddr", bus.rsp_badaddr, 32'd0);
        tick;
        reset = 1'b0;
        tick;
        bus.dm_rvalid = 1'b1;
        bus.dm_rdata  = 32'h8765_4321;
        tick;
        bus.dm_rvalid = 1'b0;
        chk("rw_drop_rsp", 32'(bus.rsp_valid), 32'd0);
        chk("rw_drop_ready", 32'(bus.req_ready), 32'd1);
        tick;
        chk("rw_drop_rsp2", 32'(bus.rsp_valid), 32'd0);
        chk("rw_drop_rdata", bus.rsp_rdata, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
